vtc_param: RTL and testbench
============================

# vtc_param

Parametrised video timing controller: generates sync, blanking, active-area and frame/line event strobes for any raster whose timings are supplied as parameters. It sits between the pixel-clock domain root and the pixel pipeline (test-pattern generator, frame-buffer reader, encoder). It is the next generation of the fixed 640x480 timing block and adds:
- programmable sync polarity
- a pixel-enable input for clock-divided rasters
- registered, glitch-free outputs
- frame and line event pulses

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low, 1 = active-high)
- VS_POL, 0, vsync asserted level
- CW, 12, counter width

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  pixel enable; timing advances only on edges where i_en=1
- o_hsync  out  1  horizontal sync at HS_POL polarity
- o_vsync  out  1  vertical sync at VS_POL polarity
- o_active  out  1  pixel inside active area
- o_hblank  out  1  x >= H_ACTIVE
- o_vblank  out  1  y >= V_ACTIVE
- o_sof  out  1  start-of-frame strobe
- o_sol  out  1  start-of-active-line strobe
- o_eol  out  1  end-of-active-line strobe
- o_eof  out  1  end-of-active-frame strobe
- o_x  out  CW  horizontal position of current outputs
- o_y  out  CW  vertical position of current outputs

One clock; reset is synchronous and active-high.

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Elaboration fails unless 2^CW >= max(H_TOTAL, V_TOTAL) and every timing parameter is >= 1.
- Internal counters: x runs 0..H_TOTAL-1 and y runs 0..V_TOTAL-1, unsigned. x increments on each enabled edge. When x = H_TOTAL-1, x wraps to 0 and y increments. y wraps to 0 after V_TOTAL-1.
- Decode of the current (x, y):
  - hsync pulse when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vsync pulse when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. Vsync is whole-line aligned: it changes only where x wraps.
  - active = (x < H_ACTIVE) && (y < V_ACTIVE).
  - sof: x=0 and y=0.
  - sol: x=0 and y < V_ACTIVE.
  - eol: x=H_ACTIVE-1 and y < V_ACTIVE.
  - eof: x=H_ACTIVE-1 and y=V_ACTIVE-1.
- Sync output level: equals the POL value while inside the pulse, and its complement otherwise.
- Level outputs (syncs, active, blanks, o_x, o_y) load the decode only on enabled edges and hold when i_en=0.
- Strobe outputs (sof/sol/eol/eof) load decode AND i_en on every edge, so each is high for exactly one i_clk cycle per event, even when i_en is sparse.
- Reset has priority over i_en.
  - Counters go to 0 and o_x/o_y go to 0.
  - o_active, o_hblank, o_vblank and all strobes go to 0.
  - o_hsync goes to ~HS_POL and o_vsync goes to ~VS_POL (deasserted).
- Reset mid-frame aborts the raster. The next enabled edge after release presents (0,0) with o_sof=1.

## Timing
- Latency: one enabled edge. Counter value (x, y) appears on outputs after the enabled edge that samples it. All outputs, including o_x and o_y, are mutually aligned.
- All outputs come directly from flops; no combinational path from inputs to outputs.
- i_en held high gives one pixel per cycle.
- i_en=1 every Nth cycle gives a raster N times slower. Levels are stable between enables; strobes are one cycle wide.
- Simultaneous events: at (0,0), sof and sol are both 1. At (H_ACTIVE-1, V_ACTIVE-1), eol and eof are both 1.
- Default timing gives a frame period of 800x525 = 420000 enabled edges.

## Structure
- Shared package vtc_pkg holds:
  - preset localparams for 640x480@60, 800x600@60 and 1280x720@60 (active/FP/sync/BP per axis, polarity)
  - function vtc_total(active, fp, sync, bp)
- One sub-module, vtc_counter: CW-wide, enabled, wrap-at-MAX counter with a wrap output. It is instantiated once for x (enable = i_en) and once for y (enable = i_en & x_wrap).
- Decode plus output registers live in vtc_param.

## Test plan
- Default parameters, i_en=1, two frames → o_sof period 420000 cycles; 640 o_active cycles per active line; o_hsync low for 96 cycles starting at o_x=656; o_vsync low for lines 490–491 (1600 cycles).
- HS_POL=1, VS_POL=1 → sync outputs idle 0 during reset and normal run, 1 only inside the pulses; pulse positions unchanged.
- i_en high every 4th cycle → all level outputs hold for 4 cycles; each strobe stays one cycle wide; o_sof period 1680000 cycles.
- Assert i_rst at x=300, y=200 for 3 cycles → during reset o_x=0, o_y=0, o_active=0, syncs deasserted; first enabled edge after release gives o_sof=1, o_sol=1, o_active=1.
- Tiny raster (H 4/1/1/1, V 2/1/1/1, CW=3) → exhaustive check of x/y wrap at 6/4 and strobe coincidence at (0,0) and (3,1) against a reference model.

Source files
------------

// File: rtl/vtc_pkg.sv
// Shared video timing presets and helpers for the vtc_* blocks.
package vtc_pkg;

    // 640x480@60, negative syncs
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_HS_POL   = 0;
    localparam int VGA_VS_POL   = 0;

    // 800x600@60, positive syncs
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    localparam int SVGA_HS_POL   = 1;
    localparam int SVGA_VS_POL   = 1;

    // 1280x720@60, positive syncs
    localparam int HD_H_ACTIVE = 1280;
    localparam int HD_H_FP     = 110;
    localparam int HD_H_SYNC   = 40;
    localparam int HD_H_BP     = 220;
    localparam int HD_V_ACTIVE = 720;
    localparam int HD_V_FP     = 5;
    localparam int HD_V_SYNC   = 5;
    localparam int HD_V_BP     = 20;
    localparam int HD_HS_POL   = 1;
    localparam int HD_VS_POL   = 1;

    function automatic int vtc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vtc_counter.sv
// Enabled up-counter that wraps to 0 after MAX; o_wrap flags the terminal count.
module vtc_counter #(
    parameter int CW  = 12,
    parameter int MAX = 799
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_wrap
);
    localparam logic [CW-1:0] LP_MAX = CW'(MAX);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LP_MAX);
    assign o_cnt  = r_cnt;
    assign o_wrap = w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/vtc_param.sv
// Parametrised video timing controller: x/y raster counters, decode and
// registered sync/blank/active/strobe outputs.
module vtc_param
    import vtc_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active,
    output logic          o_hblank,
    output logic          o_vblank,
    output logic          o_sof,
    output logic          o_sol,
    output logic          o_eol,
    output logic          o_eof,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y
);
    localparam int H_TOTAL = vtc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vtc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int MAX_TOT = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    generate
        if ((64'd1 << CW) < 64'(MAX_TOT) || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 ||
            H_BP < 1 || V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_cfg
            $error("vtc_param: invalid timing parameters or CW too narrow");
        end
    endgenerate

    localparam logic [CW-1:0] LP_H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] LP_H_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] LP_HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] LP_HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] LP_V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] LP_V_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] LP_VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] LP_VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          LP_HS_POL = 1'(HS_POL);
    localparam logic          LP_VS_POL = 1'(VS_POL);

    logic [CW-1:0] w_x, w_y;
    logic          w_x_wrap;

    vtc_counter #(.CW(CW), .MAX(H_TOTAL - 1)) u_xcnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .o_cnt (w_x),
        .o_wrap(w_x_wrap)
    );

    // y only steps on the enabled edge that wraps x, so vsync is line aligned
    vtc_counter #(.CW(CW), .MAX(V_TOTAL - 1)) u_ycnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en & w_x_wrap),
        .o_cnt (w_y),
        .o_wrap()
    );

    logic w_hs_pulse, w_vs_pulse, w_hact, w_vact;
    logic w_sof, w_sol, w_eol, w_eof;

    assign w_hs_pulse = (w_x >= LP_HS_BEG) && (w_x < LP_HS_END);
    assign w_vs_pulse = (w_y >= LP_VS_BEG) && (w_y < LP_VS_END);
    assign w_hact     = (w_x < LP_H_ACT);
    assign w_vact     = (w_y < LP_V_ACT);
    assign w_sof      = (w_x == '0) && (w_y == '0);
    assign w_sol      = (w_x == '0) && w_vact;
    assign w_eol      = (w_x == LP_H_LAST) && w_vact;
    assign w_eof      = (w_x == LP_H_LAST) && (w_y == LP_V_LAST);

    logic          r_hsync, r_vsync, r_active, r_hblank, r_vblank;
    logic          r_sof, r_sol, r_eol, r_eof;
    logic [CW-1:0] r_x, r_y;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hsync  <= ~LP_HS_POL;
            r_vsync  <= ~LP_VS_POL;
            r_active <= 1'b0;
            r_hblank <= 1'b0;
            r_vblank <= 1'b0;
            r_sof    <= 1'b0;
            r_sol    <= 1'b0;
            r_eol    <= 1'b0;
            r_eof    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            // strobes reload every edge so they stay one clock wide under sparse i_en
            r_sof <= i_en & w_sof;
            r_sol <= i_en & w_sol;
            r_eol <= i_en & w_eol;
            r_eof <= i_en & w_eof;
            if (i_en) begin
                r_hsync  <= w_hs_pulse ? LP_HS_POL : ~LP_HS_POL;
                r_vsync  <= w_vs_pulse ? LP_VS_POL : ~LP_VS_POL;
                r_active <= w_hact & w_vact;
                r_hblank <= ~w_hact;
                r_vblank <= ~w_vact;
                r_x      <= w_x;
                r_y      <= w_y;
            end
        end
    end

    assign o_hsync  = r_hsync;
    assign o_vsync  = r_vsync;
    assign o_active = r_active;
    assign o_hblank = r_hblank;
    assign o_vblank = r_vblank;
    assign o_sof    = r_sof;
    assign o_sol    = r_sol;
    assign o_eol    = r_eol;
    assign o_eof    = r_eof;
    assign o_x      = r_x;
    assign o_y      = r_y;

endmodule

// File: tb/tb_vtc_param.sv
// Bench for vtc_param: a small negative-sync raster and a tiny positive-sync
// raster, both checked cycle by cycle against a pixel-position reference model.
module tb_vtc_param;

    localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 1;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
    localparam logic A_HP = 1'b0, A_VP = 1'b0;

    localparam int B_HA = 4, B_HF = 1, B_HS = 1, B_HB = 1;
    localparam int B_VA = 2, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;
    localparam logic B_HP = 1'b1, B_VP = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en;

    logic a_hs, a_vs, a_act, a_hb, a_vb, a_sof, a_sol, a_eol, a_eof;
    logic [4:0] a_x, a_y;
    logic b_hs, b_vs, b_act, b_hb, b_vb, b_sof, b_sol, b_eol, b_eof;
    logic [2:0] b_x, b_y;

    vtc_param #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HS_POL(0), .VS_POL(0), .CW(5)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_active(a_act), .o_hblank(a_hb), .o_vblank(a_vb),
        .o_sof(a_sof), .o_sol(a_sol), .o_eol(a_eol), .o_eof(a_eof), .o_x(a_x), .o_y(a_y)
    );

    vtc_param #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HS_POL(1), .VS_POL(1), .CW(3)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_active(b_act), .o_hblank(b_hb), .o_vblank(b_vb),
        .o_sof(b_sof), .o_sol(b_sol), .o_eol(b_eol), .o_eof(b_eof), .o_x(b_x), .o_y(b_y)
    );

    logic [8:0] fa, fb;
    assign fa = {a_hs, a_vs, a_act, a_hb, a_vb, a_sof, a_sol, a_eol, a_eof};
    assign fb = {b_hs, b_vs, b_act, b_hb, b_vb, b_sof, b_sol, b_eol, b_eof};

    int vectors = 0;
    int miscompares = 0;

    // reference model: pixel position of the next enabled edge and the expected outputs
    int ax, ay, bx, by;
    logic [8:0] ea, eb;
    logic [4:0] ea_x, ea_y;
    logic [2:0] eb_x, eb_y;

    function automatic logic [8:0] decode(input int x, input int y,
                                          input int ha, input int hf, input int hs,
                                          input int va, input int vf, input int vs,
                                          input logic hp, input logic vp);
        logic in_h, in_v;
        in_h = (x >= ha + hf) && (x < ha + hf + hs);
        in_v = (y >= va + vf) && (y < va + vf + vs);
        return {in_h ? hp : ~hp, in_v ? vp : ~vp, (x < ha) && (y < va), x >= ha, y >= va,
                (x == 0) && (y == 0), (x == 0) && (y < va),
                (x == ha - 1) && (y < va), (x == ha - 1) && (y == va - 1)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ax = 0; ay = 0; bx = 0; by = 0;
            ea = {~A_HP, ~A_VP, 7'b0}; ea_x = '0; ea_y = '0;
            eb = {~B_HP, ~B_VP, 7'b0}; eb_x = '0; eb_y = '0;
        end else begin
            ea[3:0] = 4'b0;
            eb[3:0] = 4'b0;
            if (en) begin
                ea = decode(ax, ay, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, A_HP, A_VP);
                ea_x = 5'(ax); ea_y = 5'(ay);
                eb = decode(bx, by, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, B_HP, B_VP);
                eb_x = 3'(bx); eb_y = 3'(by);
                ax = (ax + 1) % A_HT;
                if (ax == 0) ay = (ay + 1) % A_VT;
                bx = (bx + 1) % B_HT;
                if (bx == 0) by = (by + 1) % B_VT;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            en = 1'(c % 2);
            @(negedge clk);
            vectors++;
            if ({fa, a_x, a_y} !== {9'b1_1000_0000, 5'd0, 5'd0}) begin
                miscompares++;
                $display("FAIL reset_a: got %h/%0d/%0d want 180/0/0", fa, a_x, a_y);
            end
            vectors++;
            if ({fb, b_x, b_y} !== {9'b0, 3'd0, 3'd0}) begin
                miscompares++;
                $display("FAIL reset_b: got %h/%0d/%0d want 000/0/0", fb, b_x, b_y);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_full_rate();
        int last_sof = -1;
        en = 1'b1;
        for (int c = 0; c < 2 * A_HT * A_VT + 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({fa, a_x, a_y} !== {ea, ea_x, ea_y}) begin
                miscompares++;
                $display("FAIL full_a c=%0d: got %h/%0d/%0d want %h/%0d/%0d", c, fa, a_x, a_y, ea, ea_x, ea_y);
            end
            vectors++;
            if ({fb, b_x, b_y} !== {eb, eb_x, eb_y}) begin
                miscompares++;
                $display("FAIL full_b c=%0d: got %h/%0d/%0d want %h/%0d/%0d", c, fb, b_x, b_y, eb, eb_x, eb_y);
            end
            if (a_sof === 1'b1) begin
                if (last_sof >= 0) begin
                    vectors++;
                    if (c - last_sof != A_HT * A_VT) begin
                        miscompares++;
                        $display("FAIL sof_period_full: got %0d want %0d", c - last_sof, A_HT * A_VT);
                    end
                end
                last_sof = c;
            end
        end
    endtask

    task automatic test_sparse_en();
        int last_sof = -1;
        logic prev_sof = 1'b0;
        for (int c = 0; c < 4 * (2 * A_HT * A_VT + 4); c++) begin
            @(negedge clk);
            vectors++;
            if ({fa, a_x, a_y} !== {ea, ea_x, ea_y}) begin
                miscompares++;
                $display("FAIL sparse_a c=%0d: got %h/%0d/%0d want %h/%0d/%0d", c, fa, a_x, a_y, ea, ea_x, ea_y);
            end
            vectors++;
            if ({fb, b_x, b_y} !== {eb, eb_x, eb_y}) begin
                miscompares++;
                $display("FAIL sparse_b c=%0d: got %h/%0d/%0d want %h/%0d/%0d", c, fb, b_x, b_y, eb, eb_x, eb_y);
            end
            if (a_sof === 1'b1) begin
                vectors++;
                if (prev_sof) begin
                    miscompares++;
                    $display("FAIL sof_width_sparse: got 2+ cycles want 1");
                end
                if (last_sof >= 0) begin
                    vectors++;
                    if (c - last_sof != 4 * A_HT * A_VT) begin
                        miscompares++;
                        $display("FAIL sof_period_sparse: got %0d want %0d", c - last_sof, 4 * A_HT * A_VT);
                    end
                end
                last_sof = c;
            end
            prev_sof = a_sof;
            en = (c % 4 == 3);
        end
    endtask

    task automatic test_random_en();
        for (int c = 0; c < 400; c++) begin
            en = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if ({fa, a_x, a_y} !== {ea, ea_x, ea_y}) begin
                miscompares++;
                $display("FAIL rand_a c=%0d: got %h/%0d/%0d want %h/%0d/%0d", c, fa, a_x, a_y, ea, ea_x, ea_y);
            end
            vectors++;
            if ({fb, b_x, b_y} !== {eb, eb_x, eb_y}) begin
                miscompares++;
                $display("FAIL rand_b c=%0d: got %h/%0d/%0d want %h/%0d/%0d", c, fb, b_x, b_y, eb, eb_x, eb_y);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        en = 1'b1;
        for (int c = 0; c < 4 * A_HT * A_VT && !found; c++) begin
            @(negedge clk);
            if (a_x === 5'd5 && a_y === 5'd2) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midrst_seek: got timeout want position (5,2)");
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({a_x, a_y, a_act, a_hs, a_vs, a_sof} !== {5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL midrst_hold c=%0d: got x=%0d y=%0d act=%b hs=%b vs=%b sof=%b want 0 0 0 1 1 0",
                         c, a_x, a_y, a_act, a_hs, a_vs, a_sof);
            end
            vectors++;
            if ({b_hs, b_vs, b_act} !== 3'b000) begin
                miscompares++;
                $display("FAIL midrst_b c=%0d: got hs=%b vs=%b act=%b want 0 0 0", c, b_hs, b_vs, b_act);
            end
        end
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if ({a_sof, a_act} !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_idle: got sof=%b act=%b want 0 0", a_sof, a_act);
        end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if ({a_sof, a_sol, a_act, a_x, a_y} !== {3'b111, 5'd0, 5'd0}) begin
            miscompares++;
            $display("FAIL midrst_first: got sof=%b sol=%b act=%b x=%0d y=%0d want 1 1 1 0 0",
                     a_sof, a_sol, a_act, a_x, a_y);
        end
    endtask

    task automatic test_tiny_coincide();
        int n_sof = 0, n_eof = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        for (int c = 0; c < 3 * B_HT * B_VT; c++) begin
            @(negedge clk);
            vectors++;
            if ({fb, b_x, b_y} !== {eb, eb_x, eb_y}) begin
                miscompares++;
                $display("FAIL tiny c=%0d: got %h/%0d/%0d want %h/%0d/%0d", c, fb, b_x, b_y, eb, eb_x, eb_y);
            end
            if (eb_x == 3'd0 && eb_y == 3'd0) begin
                n_sof++;
                vectors++;
                if ({b_sof, b_sol} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL tiny_sof_sol: got %b%b want 11", b_sof, b_sol);
                end
            end
            if (eb_x == 3'd3 && eb_y == 3'd1) begin
                n_eof++;
                vectors++;
                if ({b_eol, b_eof} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL tiny_eol_eof: got %b%b want 11", b_eol, b_eof);
                end
            end
        end
        vectors++;
        if (n_sof != 3 || n_eof != 3) begin
            miscompares++;
            $display("FAIL tiny_events: got sof=%0d eof=%0d want 3 3", n_sof, n_eof);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        test_reset();
        test_full_rate();
        test_sparse_en();
        test_random_en();
        test_mid_reset();
        test_random_en();
        test_tiny_coincide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
